mem_bus_arb: RTL and testbench

- Arbitrates a single shared memory bus between the EX stage load/store port and the instruction-fetch port.
- Sequences each access as arbitrate → address phase (req/gnt) → data phase (rvalid), with one outstanding transaction.
- Raises a pipeline hold while an EX memory access is pending.
- EX has fixed priority, with an anti-starvation guard for fetch.

---
 rtl/mem_bus_arb.sv | 169 ++++++++++++++++
 tb/tb_mem_bus_arb.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arb.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_arb
//  Description : Shared memory bus arbiter between the EX load/store port and
//                the instruction-fetch port. One outstanding transaction,
//                sequenced as arbitrate -> address phase -> data phase. EX has
//                fixed priority with a streak-based anti-starvation guard for
//                fetch, and a pipeline hold is raised while EX is pending.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arb #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_LIM = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    // EX load/store port
    input  logic                  ex_req_i,
    input  logic                  ex_we_i,
    input  logic [ADDR_W-1:0]     ex_addr_i,
    input  logic [DATA_W-1:0]     ex_wdata_i,
    input  logic [DATA_W/8-1:0]   ex_wmask_i,
    output logic                  ex_gnt_o,
    output logic                  ex_rvalid_o,
    output logic [DATA_W-1:0]     ex_rdata_o,
    // instruction-fetch port
    input  logic                  if_req_i,
    input  logic [ADDR_W-1:0]     if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [DATA_W-1:0]     if_rdata_o,
    // shared memory bus
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [ADDR_W-1:0]     bus_addr_o,
    output logic [DATA_W-1:0]     bus_wdata_o,
    output logic [DATA_W/8-1:0]   bus_wmask_o,
    input  logic                  bus_gnt_i,
    input  logic                  bus_rvalid_i,
    input  logic [DATA_W-1:0]     bus_rdata_i,
    // pipeline stall request
    output logic                  hold_o
);

    localparam int         c_MASK_W     = DATA_W / 8;
    localparam logic [2:0] c_STREAK_MAX = 3'(STARVE_LIM);
    localparam logic       c_OWN_EX     = 1'b0;
    localparam logic       c_OWN_IF     = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_arb;
    logic                  w_pick_if;

    logic                  r_owner;
    logic [2:0]            r_streak;
    logic                  r_we;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [c_MASK_W-1:0]   r_wmask;

    logic                  w_in_addr;
    logic                  w_in_data;
    logic                  w_ex_own;
    logic                  w_ex_rvalid;
    logic                  w_if_rvalid;

    // Fetch wins when EX is absent, or when EX has starved a waiting fetch long enough.
    assign w_pick_if = if_req_i & (~ex_req_i | (r_streak == c_STREAK_MAX));

    // Next-state logic: arbitrate in IDLE, wait for gnt in ADDR, wait for rvalid in DATA.
    always_comb begin
        w_state_nxt = r_state;
        w_arb       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ex_req_i | if_req_i) begin
                    w_arb       = 1'b1;
                    w_state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                if (bus_gnt_i) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (bus_rvalid_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Owner, streak and request fields are captured only at arbitration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner  <= c_OWN_EX;
            r_streak <= 3'd0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_wmask  <= '0;
        end else if (w_arb) begin
            if (w_pick_if) begin
                r_owner  <= c_OWN_IF;
                r_streak <= 3'd0;
                r_we     <= 1'b0;
                r_addr   <= if_addr_i;
                r_wdata  <= '0;
                r_wmask  <= '0;
            end else begin
                r_owner  <= c_OWN_EX;
                // Streak counts only EX wins that made a fetch wait.
                if (if_req_i) begin
                    r_streak <= (r_streak == c_STREAK_MAX) ? r_streak : r_streak + 3'd1;
                end else begin
                    r_streak <= 3'd0;
                end
                r_we     <= ex_we_i;
                r_addr   <= ex_addr_i;
                r_wdata  <= ex_wdata_i;
                r_wmask  <= ex_wmask_i;
            end
        end
    end

    assign w_in_addr   = (r_state == S_ADDR);
    assign w_in_data   = (r_state == S_DATA);
    assign w_ex_own    = (r_owner == c_OWN_EX);
    assign w_ex_rvalid = w_in_data & w_ex_own & bus_rvalid_i;
    assign w_if_rvalid = w_in_data & ~w_ex_own & bus_rvalid_i;

    assign bus_req_o   = w_in_addr;
    assign bus_we_o    = r_we;
    assign bus_addr_o  = r_addr;
    assign bus_wdata_o = r_wdata;
    assign bus_wmask_o = r_wmask;

    // Handshakes are routed only to the current owner; the other port sees zeros.
    assign ex_gnt_o    = w_in_addr & w_ex_own & bus_gnt_i;
    assign if_gnt_o    = w_in_addr & ~w_ex_own & bus_gnt_i;
    assign ex_rvalid_o = w_ex_rvalid;
    assign if_rvalid_o = w_if_rvalid;
    assign ex_rdata_o  = w_ex_rvalid ? bus_rdata_i : '0;
    assign if_rdata_o  = w_if_rvalid ? bus_rdata_i : '0;

    // Hold stays up until the cycle in which the EX data phase completes.
    assign hold_o = (ex_req_i | (w_ex_own & (r_state != S_IDLE))) & ~w_ex_rvalid;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_bus_arb
//  Description : Self-checking bench for mem_bus_arb: directed scenarios plus
//                randomized requesters and slave, compared every cycle against
//                a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arb;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STARVE_LIM = 4;
    localparam int MASK_W     = DATA_W / 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                ex_req_i = 1'b0, ex_we_i = 1'b0;
    logic [ADDR_W-1:0]   ex_addr_i = '0;
    logic [DATA_W-1:0]   ex_wdata_i = '0;
    logic [MASK_W-1:0]   ex_wmask_i = '0;
    logic                ex_gnt_o, ex_rvalid_o;
    logic [DATA_W-1:0]   ex_rdata_o;
    logic                if_req_i = 1'b0;
    logic [ADDR_W-1:0]   if_addr_i = '0;
    logic                if_gnt_o, if_rvalid_o;
    logic [DATA_W-1:0]   if_rdata_o;
    logic                bus_req_o, bus_we_o;
    logic [ADDR_W-1:0]   bus_addr_o;
    logic [DATA_W-1:0]   bus_wdata_o;
    logic [MASK_W-1:0]   bus_wmask_o;
    logic                bus_gnt_i = 1'b0, bus_rvalid_i = 1'b0;
    logic [DATA_W-1:0]   bus_rdata_i = '0;
    logic                hold_o;

    mem_bus_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIM(STARVE_LIM)) u_dut (
        .clk(clk), .rst(rst),
        .ex_req_i(ex_req_i), .ex_we_i(ex_we_i), .ex_addr_i(ex_addr_i),
        .ex_wdata_i(ex_wdata_i), .ex_wmask_i(ex_wmask_i),
        .ex_gnt_o(ex_gnt_o), .ex_rvalid_o(ex_rvalid_o), .ex_rdata_o(ex_rdata_o),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i),
        .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_wmask_o(bus_wmask_o),
        .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
        .hold_o(hold_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    // m_busy: a transaction is owned; m_granted: its address phase was accepted.
    bit                m_busy, m_granted, m_own_if;
    int                m_streak;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [MASK_W-1:0] m_wmask;

    function automatic void m_reset();
        m_busy = 0; m_granted = 0; m_own_if = 0; m_streak = 0;
        m_we = 0; m_addr = '0; m_wdata = '0; m_wmask = '0;
    endfunction

    // Advance the model by one clock using the inputs present at that edge.
    function automatic void m_clock();
        bit fetch_first;
        if (!m_busy) begin
            if (ex_req_i || if_req_i) begin
                fetch_first = if_req_i && (!ex_req_i || m_streak == STARVE_LIM);
                m_busy = 1; m_granted = 0; m_own_if = fetch_first;
                if (fetch_first) begin
                    m_streak = 0;
                    m_we = 0; m_addr = if_addr_i; m_wdata = '0; m_wmask = '0;
                end else begin
                    m_streak = if_req_i ? ((m_streak < STARVE_LIM) ? m_streak + 1 : STARVE_LIM) : 0;
                    m_we = ex_we_i; m_addr = ex_addr_i; m_wdata = ex_wdata_i; m_wmask = ex_wmask_i;
                end
            end
        end else if (!m_granted) begin
            if (bus_gnt_i) m_granted = 1;
        end else if (bus_rvalid_i) begin
            m_busy = 0; m_granted = 0;
        end
    endfunction

    // Captured DUT outputs from the last checked cycle (for directed checks).
    logic o_breq, o_exg, o_ifg, o_exv, o_ifv, o_hold;
    logic [DATA_W-1:0] o_exrd, o_ifrd;

    task automatic check_outputs();
        bit addr_ph, data_ph, e_exg, e_ifg, e_exv, e_ifv, e_hold;
        addr_ph = m_busy && !m_granted;
        data_ph = m_busy && m_granted;
        e_exg   = addr_ph && !m_own_if && bus_gnt_i;
        e_ifg   = addr_ph &&  m_own_if && bus_gnt_i;
        e_exv   = data_ph && !m_own_if && bus_rvalid_i;
        e_ifv   = data_ph &&  m_own_if && bus_rvalid_i;
        e_hold  = (ex_req_i || (!m_own_if && m_busy)) && !e_exv;
        check_val("bus_req", bus_req_o, addr_ph);
        check_val("ex_gnt", ex_gnt_o, e_exg);
        check_val("if_gnt", if_gnt_o, e_ifg);
        check_val("ex_rvalid", ex_rvalid_o, e_exv);
        check_val("if_rvalid", if_rvalid_o, e_ifv);
        check_val("hold", hold_o, e_hold);
        check_val("gnt_excl", ex_gnt_o & if_gnt_o, 1'b0);
        if (addr_ph) begin
            check_val("bus_we", bus_we_o, m_we);
            check_val("bus_addr", bus_addr_o, m_addr);
            check_val("bus_wdata", bus_wdata_o, m_wdata);
            check_val("bus_wmask", bus_wmask_o, m_wmask);
        end
        if (e_exv) check_val("ex_rdata", ex_rdata_o, bus_rdata_i);
        if (e_ifv) check_val("if_rdata", if_rdata_o, bus_rdata_i);
        if (m_own_if) check_val("ex_rdata_iso", ex_rdata_o, '0);
        else          check_val("if_rdata_iso", if_rdata_o, '0);
        o_breq = bus_req_o; o_exg = ex_gnt_o; o_ifg = if_gnt_o;
        o_exv = ex_rvalid_o; o_ifv = if_rvalid_o; o_hold = hold_o;
        o_exrd = ex_rdata_o; o_ifrd = if_rdata_o;
    endtask

    // One cycle: inputs already applied after a falling edge.
    task automatic tick();
        #1 check_outputs();
        @(posedge clk);
        m_clock();
        @(negedge clk);
    endtask

    task automatic do_reset();
        ex_req_i = 0; if_req_i = 0; bus_gnt_i = 0; bus_rvalid_i = 0;
        ex_we_i = 0; ex_addr_i = '0; ex_wdata_i = '0; ex_wmask_i = '0; if_addr_i = '0;
        rst = 1;
        m_reset();
        @(negedge clk);
        #1 check_outputs();
        check_val("rst_bus_addr", bus_addr_o, '0);
        check_val("rst_bus_wdata", bus_wdata_o, '0);
        check_val("rst_bus_wmask", bus_wmask_o, '0);
        check_val("rst_bus_we", bus_we_o, 1'b0);
        @(negedge clk);
        rst = 0;
    endtask

    int ex_gnts, grant_cnt, ex_while_if;
    bit seen;
    logic [ADDR_W-1:0] grants [$];

    initial begin
        // ---- EX-only load, zero-wait slave ----
        do_reset();
        ex_req_i = 1; ex_we_i = 0; ex_addr_i = 32'h100;
        bus_gnt_i = 1; bus_rvalid_i = 1; bus_rdata_i = 32'hDEADBEEF;
        tick();
        check_val("ld_c0_breq", o_breq, 1'b0);
        check_val("ld_c0_hold", o_hold, 1'b1);
        tick();
        check_val("ld_c1_breq", o_breq, 1'b1);
        check_val("ld_c1_gnt", o_exg, 1'b1);
        check_val("ld_c1_hold", o_hold, 1'b1);
        ex_req_i = 0;
        tick();
        check_val("ld_c2_rvalid", o_exv, 1'b1);
        check_val("ld_c2_rdata", o_exrd, 32'hDEADBEEF);
        check_val("ld_c2_hold", o_hold, 1'b0);
        bus_gnt_i = 0; bus_rvalid_i = 0;
        tick();

        // ---- EX store with two gnt wait states ----
        ex_req_i = 1; ex_we_i = 1; ex_addr_i = 32'h200;
        ex_wdata_i = 32'h12345678; ex_wmask_i = 4'b0011;
        ex_gnts = 0;
        tick();                                   // arbitration
        for (int i = 0; i < 3; i++) begin
            bus_gnt_i = (i == 2);
            tick();
            check_val("st_breq", o_breq, 1'b1);
            ex_gnts += int'(o_exg);
        end
        check_val("st_gnt_count", ex_gnts, 1);
        ex_req_i = 0; bus_gnt_i = 0; bus_rvalid_i = 1; bus_rdata_i = 32'h0;
        tick();
        check_val("st_ack", o_exv, 1'b1);
        bus_rvalid_i = 0;
        tick();

        // ---- simultaneous requests, then spurious pulses ----
        ex_req_i = 1; ex_we_i = 0; ex_addr_i = 32'h300;
        if_req_i = 1; if_addr_i = 32'h400;
        bus_gnt_i = 1; bus_rvalid_i = 1; bus_rdata_i = 32'hCAFE0001;
        seen = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            tick();
            if (o_exg) ex_req_i = 0;
            if (o_ifg) begin
                if_req_i = 0;
                check_val("sim_if_after_ex", ex_req_i, 1'b0);
            end
            if (o_ifv) begin
                seen = 1;
                check_val("sim_if_rdata", o_ifrd, 32'hCAFE0001);
            end
        end
        check_val("sim_if_done", seen, 1'b1);
        // spurious gnt in DATA, spurious rvalid in ADDR
        ex_req_i = 1; ex_addr_i = 32'h500; bus_gnt_i = 0; bus_rvalid_i = 1;
        tick(); tick();
        bus_gnt_i = 1; bus_rvalid_i = 0; tick();
        ex_req_i = 0; bus_gnt_i = 1; tick(); tick();
        bus_gnt_i = 0; bus_rvalid_i = 1; tick();
        bus_rvalid_i = 0; tick();

        // ---- starvation guard: both requests held continuously ----
        do_reset();
        ex_req_i = 1; if_req_i = 1; ex_addr_i = 32'h600; if_addr_i = 32'h700;
        bus_gnt_i = 1; bus_rvalid_i = 1;
        grants.delete();
        for (int i = 0; i < 60 && grants.size() < 10; i++) begin
            tick();
            if (o_exg) grants.push_back(32'h0);
            if (o_ifg) grants.push_back(32'h1);
        end
        check_val("starve_count", grants.size(), 10);
        for (int k = 0; k < grants.size(); k++)
            check_val($sformatf("starve_order%0d", k), grants[k],
                      (k % (STARVE_LIM + 1) == STARVE_LIM) ? 32'h1 : 32'h0);
        ex_req_i = 0; if_req_i = 0; bus_gnt_i = 0; bus_rvalid_i = 0;

        // ---- reset in the middle of an EX data phase ----
        do_reset();
        ex_req_i = 1; ex_addr_i = 32'h800; bus_gnt_i = 1;
        tick(); tick();
        ex_req_i = 0; bus_gnt_i = 0; bus_rvalid_i = 1; bus_rdata_i = 32'h55;
        rst = 1;
        #1;
        check_val("rstmid_breq", bus_req_o, 1'b0);
        check_val("rstmid_rvalid", ex_rvalid_o, 1'b0);
        check_val("rstmid_gnt", ex_gnt_o | if_gnt_o | if_rvalid_o, 1'b0);
        check_val("rstmid_hold", hold_o, ex_req_i);
        m_reset();
        @(negedge clk);
        rst = 0; bus_rvalid_i = 0; bus_gnt_i = 1;
        if_req_i = 1; if_addr_i = 32'h900;
        seen = 0;
        for (int i = 0; i < 6 && !seen; i++) begin
            tick();
            if (o_ifg) begin seen = 1; if_req_i = 0; end
        end
        check_val("rstmid_if_gnt", seen, 1'b1);
        bus_gnt_i = 0; bus_rvalid_i = 1; tick();
        bus_rvalid_i = 0; tick();

        // ---- randomized traffic against the model ----
        ex_while_if = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (!ex_req_i && ($urandom_range(0, 2) == 0)) begin
                ex_req_i = 1; ex_we_i = 1'($urandom);
                ex_addr_i = $urandom; ex_wdata_i = $urandom; ex_wmask_i = 4'($urandom);
            end
            if (!if_req_i && ($urandom_range(0, 2) == 0)) begin
                if_req_i = 1; if_addr_i = $urandom;
                ex_while_if = 0;
            end
            bus_gnt_i = 1'($urandom); bus_rvalid_i = 1'($urandom); bus_rdata_i = $urandom;
            tick();
            if (o_exg) begin
                ex_req_i = 0;
                if (if_req_i) ex_while_if++;
            end
            if (o_ifg) begin
                if_req_i = 0;
                check_val("rnd_starve_bound", (ex_while_if <= STARVE_LIM + 1), 1'b1);
            end
            if (cyc % 1000 == 999) begin
                do_reset();
                ex_while_if = 0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
